// File: rtl/calc_pkg.sv
// Shared types and keypad map for the calculator front end.
// Grid cells 0..15 are hex digits; cells 16..23 are operators and controls.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    S_OP1  = 2'd0,
    S_OP2  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_DIGIT,
    K_OPER,
    K_CE,
    K_CLR,
    K_EXE
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] digit;
    op_t        op;
  } key_t;

  localparam int GRID_W = 6;
  localparam int GRID_H = 4;

  localparam logic [4:0] IDX_ADD = 5'd16;
  localparam logic [4:0] IDX_SUB = 5'd17;
  localparam logic [4:0] IDX_MUL = 5'd18;
  localparam logic [4:0] IDX_AND = 5'd19;
  localparam logic [4:0] IDX_OR  = 5'd20;
  localparam logic [4:0] IDX_CE  = 5'd21;
  localparam logic [4:0] IDX_CLR = 5'd22;
  localparam logic [4:0] IDX_EXE = 5'd23;

  function automatic key_t key_at(
    input logic [2:0] x,
    input logic [1:0] y
  );
    logic [4:0] idx;
    key_t       k;
    idx = 5'(y) * 5'd6 + 5'(x);
    k.kind  = K_NONE;
    k.digit = idx[3:0];
    k.op    = OP_ADD;
    if (idx < 5'd16) begin
      k.kind = K_DIGIT;
    end else begin
      case (idx)
        IDX_ADD: begin k.kind = K_OPER; k.op = OP_ADD; end
        IDX_SUB: begin k.kind = K_OPER; k.op = OP_SUB; end
        IDX_MUL: begin k.kind = K_OPER; k.op = OP_MUL; end
        IDX_AND: begin k.kind = K_OPER; k.op = OP_AND; end
        IDX_OR:  begin k.kind = K_OPER; k.op = OP_OR;  end
        IDX_CE:  k.kind = K_CE;
        IDX_CLR: k.kind = K_CLR;
        IDX_EXE: k.kind = K_EXE;
        default: k.kind = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Multi-flop synchronizer followed by a rising- or any-edge detector.
// edge_o is high for one cycle per synchronized transition.
module button_edge_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit BOTH_EDGES  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, d_i});
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = BOTH_EDGES ? (level_o ^ prev_q)
                              : (level_o & ~prev_q);

endmodule

// File: rtl/calculator_input_ctrl.sv
// Keypad controller: cursor motion over the 6x4 grid and operand entry.
// Drives operands, opcode and a one-cycle exe strobe to the ALU/screen.
module calculator_input_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic [2:0]  op,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [15:0] input_screen,
  output logic        exe
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [4:0] btn_raw;
  logic [4:0] rise;
  logic [4:0] lvl_unused;
  logic       mode_s;
  logic       mode_chg;

  assign btn_raw = {btn_center, btn_up, btn_down,
                    btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES),
      .BOTH_EDGES (1'b0)
    ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (btn_raw[i]),
      .level_o(lvl_unused[i]),
      .edge_o (rise[i])
    );
  end

  button_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES),
    .BOTH_EDGES (1'b1)
  ) u_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (mode),
    .level_o(mode_s),
    .edge_o (mode_chg)
  );

  logic act_c, act_u, act_d, act_l, act_r;

  assign act_c = rise[4];
  assign act_u = rise[3] & ~rise[4];
  assign act_d = rise[2] & ~|rise[4:3];
  assign act_l = rise[1] & ~|rise[4:2];
  assign act_r = rise[0] & ~|rise[4:1];

  state_t      state_q, state_d;
  logic [2:0]  pos_x_q, pos_x_d;
  logic [1:0]  pos_y_q, pos_y_d;
  op_t         op_q, op_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic [15:0] scr_q, scr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        exe_q, exe_d;

  key_t key;
  logic digit_ok;

  assign key      = key_at(pos_x_q, pos_y_q);
  assign digit_ok = mode_s | (key.digit <= 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_OP1;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
      op_q    <= OP_ADD;
      op1_q   <= '0;
      op2_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      exe_q   <= 1'b0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      exe_q   <= exe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    exe_d   = 1'b0;
    // A mode flip invalidates any half-typed operand, so it clears like CLR.
    if (mode_chg || (act_c && key.kind == K_CLR)) begin
      state_d = S_OP1;
      op_d    = OP_ADD;
      op1_d   = '0;
      op2_d   = '0;
      scr_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (1'b1)
        act_c: begin
          case (key.kind)
            K_DIGIT: begin
              if (digit_ok) begin
                if (state_q == S_DONE) begin
                  state_d = S_OP1;
                  op1_d   = '0;
                  op2_d   = '0;
                  scr_d   = {12'h000, key.digit};
                  cnt_d   = CW'(1);
                end else if (cnt_q < CW'(MAX_DIGITS)) begin
                  scr_d = {scr_q[11:0], key.digit};
                  cnt_d = cnt_q + CW'(1);
                end
              end
            end
            K_OPER: begin
              if (state_q == S_OP1) begin
                op1_d   = scr_q;
                op_d    = key.op;
                scr_d   = '0;
                cnt_d   = '0;
                state_d = S_OP2;
              end else if (state_q == S_OP2) begin
                op_d = key.op;
              end
            end
            K_EXE: begin
              if (state_q == S_OP2) begin
                op2_d   = scr_q;
                exe_d   = 1'b1;
                state_d = S_DONE;
              end
            end
            K_CE: begin
              scr_d = '0;
              cnt_d = '0;
              if (state_q == S_DONE) state_d = S_OP1;
            end
            default: ;
          endcase
        end
        act_u: pos_y_d = pos_y_q - 2'd1;
        act_d: pos_y_d = pos_y_q + 2'd1;
        act_l: pos_x_d = (pos_x_q == 3'd0) ? 3'd5
                                           : pos_x_q - 3'd1;
        act_r: pos_x_d = (pos_x_q == 3'd5) ? 3'd0
                                           : pos_x_q + 3'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_x        = pos_x_q;
    pos_y        = pos_y_q;
    op           = op_q;
    op1          = op1_q;
    op2          = op2_q;
    input_screen = scr_q;
    exe          = exe_q;
  end

endmodule

// File: tb/tb_calculator_input_ctrl.sv
// Randomized bench for calculator_input_ctrl against a keypad model.
// Each press is held for three cycles then released.
module tb_calculator_input_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic b_up, b_down, b_left, b_right, b_center;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic [2:0]  op;
  logic [15:0] op1, op2, input_screen;
  logic        exe;

  int tests_run = 0;
  int fails     = 0;
  int exe_seen  = 0;

  int mx, my, mop, mop1, mop2, mscr, mcnt, mst, mexe;
  bit mhex;

  localparam logic [4:0] C = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  always #5 clk = ~clk;

  calculator_input_ctrl #(
    .MAX_DIGITS (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .btn_up      (b_up),
    .btn_down    (b_down),
    .btn_left    (b_left),
    .btn_right   (b_right),
    .btn_center  (b_center),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .op          (op),
    .op1         (op1),
    .op2         (op2),
    .input_screen(input_screen),
    .exe         (exe)
  );

  always @(negedge clk) if (exe === 1'b1) exe_seen++;

  function automatic logic [55:0] exp_vec();
    return {mx[2:0], my[1:0], mop[2:0],
            mop1[15:0], mop2[15:0], mscr[15:0]};
  endfunction

  function automatic logic [55:0] dut_vec();
    return {pos_x, pos_y, op, op1, op2, input_screen};
  endfunction

  task automatic model_clear();
    mop = 0; mop1 = 0; mop2 = 0;
    mscr = 0; mcnt = 0; mst = 0;
  endtask

  // mst: 0 = typing op1, 1 = typing op2, 2 = result issued
  task automatic model_key();
    int idx;
    idx = my * 6 + mx;
    if (idx < 16) begin
      if (!mhex && idx > 9) return;
      if (mst == 2) begin
        mop1 = 0; mop2 = 0; mscr = idx; mcnt = 1; mst = 0;
      end else if (mcnt < 4) begin
        mscr = (mscr * 16 + idx) % 65536;
        mcnt++;
      end
    end else if (idx <= 20) begin
      if (mst == 0) begin
        mop1 = mscr; mop = idx - 16; mscr = 0; mcnt = 0; mst = 1;
      end else if (mst == 1) begin
        mop = idx - 16;
      end
    end else if (idx == 21) begin
      mscr = 0; mcnt = 0;
      if (mst == 2) mst = 0;
    end else if (idx == 22) begin
      model_clear();
    end else if (mst == 1) begin
      mop2 = mscr; mexe++; mst = 2;
    end
  endtask

  task automatic model_press(input logic [4:0] m);
    if (m[4])      model_key();
    else if (m[3]) my = (my + 3) % 4;
    else if (m[2]) my = (my + 1) % 4;
    else if (m[1]) mx = (mx + 5) % 6;
    else if (m[0]) mx = (mx + 1) % 6;
  endtask

  task automatic drive(input logic [4:0] m);
    {b_center, b_up, b_down, b_left, b_right} = m;
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk);
    drive(m);
    repeat (3) @(negedge clk);
    drive(5'b0);
    repeat (2) @(negedge clk);
    model_press(m);
  endtask

  task automatic goto(input int x, input int y);
    while (mx != x) press(R);
    while (my != y) press(D);
  endtask

  task automatic set_mode(input logic v);
    @(negedge clk);
    mode = v;
    repeat (4) @(negedge clk);
    mhex = v;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    mode  = 1'b0;
    drive(5'b0);
    #1 rst_n = 1'b0;
    #12;
    tests_run++;
    if ({dut_vec(), exe} !== 57'd0) begin
      fails++;
      $display("FAIL reset_low: got %h want 0", {dut_vec(), exe});
    end
    mx = 0; my = 0; mexe = 0; mhex = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (dut_vec() !== exp_vec() || exe !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got %h want %h",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_cursor();
    for (int i = 1; i <= 7; i++) begin
      press(R);
      tests_run++;
      if (pos_x !== 3'(i % 6) || pos_y !== 2'd0) begin
        fails++;
        $display("FAIL cursor_right %0d: got x=%0d y=%0d want x=%0d y=0",
                 i, pos_x, pos_y, i % 6);
      end
    end
    press(U);
    tests_run++;
    if (pos_y !== 2'd3 || pos_x !== 3'd1) begin
      fails++;
      $display("FAIL cursor_up_wrap: got x=%0d y=%0d want x=1 y=3",
               pos_x, pos_y);
    end
  endtask

  task automatic test_hex_entry();
    logic [15:0] old;
    int n;
    bit changed;
    set_mode(1'b1);
    goto(1, 0);
    press(C);
    goto(4, 1);
    old = input_screen;
    @(negedge clk);
    drive(C);
    n = 0;
    changed = 0;
    for (int k = 0; k < 8 && !changed; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (input_screen !== old) changed = 1;
    end
    @(negedge clk);
    drive(5'b0);
    repeat (2) @(negedge clk);
    model_press(C);
    tests_run++;
    if (!changed || n != 3) begin
      fails++;
      $display("FAIL digit_latency: got %0d edges (changed=%0d) want 3",
               n, changed);
    end
    goto(3, 0);
    press(C);
    tests_run++;
    if (input_screen !== 16'h01A3 || dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL hex_entry: got %h want 01a3", input_screen);
    end
  endtask

  task automatic test_overflow();
    goto(3, 3);
    press(C);
    for (int d = 1; d <= 5; d++) begin
      goto(d, 0);
      press(C);
    end
    tests_run++;
    if (input_screen !== 16'h1234 || dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL digit_overflow: got %h want 1234", input_screen);
    end
    set_mode(1'b0);
    goto(5, 0);
    press(C);
    goto(4, 1);
    press(C);
    tests_run++;
    if (input_screen !== 16'h0005 || dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL decimal_reject: got %h want 0005", input_screen);
    end
  endtask

  task automatic test_op_exe();
    int e0;
    goto(3, 3); press(C);
    goto(1, 0); press(C);
    goto(2, 0); press(C);
    goto(4, 2); press(C);
    goto(3, 0); press(C);
    e0 = exe_seen;
    goto(5, 3); press(C);
    tests_run++;
    if (op1 !== 16'h0012 || op !== 3'd0 || op2 !== 16'h0003 ||
        input_screen !== 16'h0003) begin
      fails++;
      $display("FAIL exe_operands: got op1=%h op=%0d op2=%h scr=%h want 0012 0 0003 0003",
               op1, op, op2, input_screen);
    end
    tests_run++;
    if (exe_seen - e0 != 1) begin
      fails++;
      $display("FAIL exe_pulse: got %0d cycles want 1", exe_seen - e0);
    end
    goto(1, 1); press(C);
    tests_run++;
    if (op1 !== 16'h0 || op2 !== 16'h0 || input_screen !== 16'h0007 ||
        dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL done_digit: got op1=%h op2=%h scr=%h want 0 0 0007",
               op1, op2, input_screen);
    end
  endtask

  task automatic test_simultaneous();
    goto(3, 3); press(C);
    goto(1, 0); press(C);
    goto(0, 0);
    press(C | R);
    tests_run++;
    if (input_screen !== 16'h0010 || pos_x !== 3'd0) begin
      fails++;
      $display("FAIL center_priority: got scr=%h x=%0d want 0010 x=0",
               input_screen, pos_x);
    end
    @(negedge clk);
    drive(C);
    repeat (1000) @(negedge clk);
    drive(5'b0);
    repeat (2) @(negedge clk);
    model_press(C);
    tests_run++;
    if (input_screen !== 16'h0100 || dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL long_hold: got %h want 0100", input_screen);
    end
  endtask

  task automatic test_mode_toggle();
    int e0;
    goto(4, 2); press(C);
    goto(1, 3); press(C);
    tests_run++;
    if (op !== 3'd3 || op1 !== 16'h0100) begin
      fails++;
      $display("FAIL op_replace: got op=%0d op1=%h want 3 0100", op, op1);
    end
    set_mode(~mode);
    tests_run++;
    if (dut_vec() !== exp_vec() || op1 !== 16'h0 || op !== 3'd0) begin
      fails++;
      $display("FAIL mode_clear: got %h want %h", dut_vec(), exp_vec());
    end
    e0 = exe_seen;
    goto(5, 3); press(C);
    tests_run++;
    if (exe_seen != e0 || op2 !== 16'h0) begin
      fails++;
      $display("FAIL exe_in_op1: got %0d pulses op2=%h want 0 0",
               exe_seen - e0, op2);
    end
  endtask

  task automatic test_async_reset();
    goto(2, 1); press(C);
    goto(3, 0); press(C);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({dut_vec(), exe} !== 57'd0) begin
      fails++;
      $display("FAIL async_reset: got %h want 0", {dut_vec(), exe});
    end
    mx = 0; my = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mhex = mode;
    model_clear();
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL after_reset: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [4:0] m;
    int e0, x0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        set_mode(~mode);
      end else begin
        if ($urandom_range(0, 3) != 0)
          m = 5'(1 << $urandom_range(0, 4));
        else
          m = 5'($urandom_range(1, 31));
        e0 = exe_seen;
        x0 = mexe;
        press(m);
        tests_run++;
        if (exe_seen - e0 != mexe - x0) begin
          fails++;
          $display("FAIL rand_exe %0d: got %0d pulses want %0d",
                   i, exe_seen - e0, mexe - x0);
        end
      end
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL rand_state %0d: got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_cursor();
    test_hex_entry();
    test_overflow();
    test_op_exe();
    test_simultaneous();
    test_mode_toggle();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
